// File: rtl/mmu_result_drainer.sv
// Read-side drainer for the systolic MMU array: freezes the array, streams its
// LENGTH rows over valid/ready, then pulses clear. Optional ReLU: MMU_DRAIN_RELU_EN.
module mmu_result_drainer #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 16,
  localparam int ELEM_W = 2 * WIDTH,
  localparam int ROW_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic                                  CLK,
  input  logic                                  SYNC_RST,
  input  logic                                  START,
  input  logic [LENGTH-1:0][LENGTH-1:0][ELEM_W-1:0] RESULT,
  output logic                                  ARRAY_HOLD,
  output logic                                  ARRAY_CLR,
  output logic                                  OUT_VALID,
  input  logic                                  OUT_READY,
  output logic [ELEM_W*LENGTH-1:0]              OUT_DATA,
  output logic [ROW_W-1:0]                      OUT_ROW,
  output logic                                  OUT_LAST,
  output logic                                  BUSY,
  output logic                                  DONE
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic                      hold_d;
  logic                      clr_d;
  logic                      valid_d;
  logic [ELEM_W*LENGTH-1:0]  data_d;
  logic [ROW_W-1:0]          row_d;
  logic                      last_d;
  logic                      busy_d;
  logic                      done_d;
  logic                      load_en;
  logic [ROW_W-1:0]          load_idx;

  // Column 0 lands in the least-significant element; negatives clamp to zero
  // only when the ReLU option is compiled in.
  function automatic logic [ELEM_W*LENGTH-1:0] pack_row(
    input logic [LENGTH-1:0][ELEM_W-1:0] row
  );
    logic [ELEM_W*LENGTH-1:0] packed_row;
    packed_row = '0;
    for (int c = 0; c < LENGTH; c++) begin
`ifdef MMU_DRAIN_RELU_EN
      packed_row[c*ELEM_W +: ELEM_W] = row[c][ELEM_W-1] ? '0 : row[c];
`else
      packed_row[c*ELEM_W +: ELEM_W] = row[c];
`endif
    end
    return packed_row;
  endfunction

  always_ff @(posedge CLK) begin
    if (!SYNC_RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every output is a register; the next values come from the decode below.
  always_ff @(posedge CLK) begin
    if (!SYNC_RST) begin
      ARRAY_HOLD <= 1'b0;
      ARRAY_CLR  <= 1'b0;
      OUT_VALID  <= 1'b0;
      OUT_DATA   <= '0;
      OUT_ROW    <= '0;
      OUT_LAST   <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      ARRAY_HOLD <= hold_d;
      ARRAY_CLR  <= clr_d;
      OUT_VALID  <= valid_d;
      OUT_DATA   <= data_d;
      OUT_ROW    <= row_d;
      OUT_LAST   <= last_d;
      BUSY       <= busy_d;
      DONE       <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = ARRAY_HOLD;
    clr_d    = 1'b0;
    valid_d  = OUT_VALID;
    data_d   = OUT_DATA;
    row_d    = OUT_ROW;
    last_d   = OUT_LAST;
    busy_d   = BUSY;
    done_d   = 1'b0;
    load_en  = 1'b0;
    load_idx = '0;

    unique case (state_q)
      IDLE: begin
        hold_d  = 1'b0;
        valid_d = 1'b0;
        if (START) begin
          state_d  = DRAIN;
          load_en  = 1'b1;
          load_idx = '0;
          hold_d   = 1'b1;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      DRAIN: begin
        // A held row stays untouched until the consumer takes it.
        if (OUT_VALID && OUT_READY) begin
          if (OUT_ROW == LAST_ROW) begin
            state_d = CLEAR;
            valid_d = 1'b0;
            last_d  = 1'b0;
            clr_d   = 1'b1;
          end else begin
            load_en  = 1'b1;
            load_idx = OUT_ROW + 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d = IDLE;
        hold_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_en) begin
      data_d = pack_row(RESULT[load_idx]);
      row_d  = load_idx;
      last_d = (load_idx == LAST_ROW);
    end
  end

endmodule

// File: doc/mmu_result_drainer.md
Name: mmu_result_drainer

Overview:
- Read-side controller for the systolic matrix-multiply array.
- After a compute pass, freezes the array (holds its EN low) and streams the LENGTH x LENGTH accumulated results out, one row per transfer, over a valid/ready interface.
- After the last row is accepted, pulses the array's clear so the next pass starts from zero.
- Sits between the array's Result bus and the downstream activation/writeback stage.

Parameters:
- WIDTH, 8, operand width of the array; each result element is 2*WIDTH bits.
- LENGTH, 16, array dimension; number of rows drained and elements per row.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- SYNC_RST  input  1  reset, synchronous, active-low.
- START  input  1  single-cycle pulse: compute pass finished, begin drain.
- RESULT  input  2*WIDTH x [LENGTH][LENGTH]  array accumulator outputs, indexed [row][col].
- ARRAY_HOLD  output  1  high = array EN must be forced low.
- ARRAY_CLR  output  1  one-cycle synchronous clear request to the array.
- OUT_VALID  output  1  OUT_DATA holds a valid row.
- OUT_READY  input  1  downstream accepts the row this cycle.
- OUT_DATA  output  2*WIDTH*LENGTH  current row; column 0 in the least-significant element.
- OUT_ROW  output  max(1,$clog2(LENGTH))  index of the row on OUT_DATA.
- OUT_LAST  output  1  high with OUT_VALID when OUT_ROW == LENGTH-1.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle pulse when the drain plus clear completes.

Behaviour:
- Reset (SYNC_RST==0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: ARRAY_HOLD, ARRAY_CLR, OUT_VALID, OUT_DATA, OUT_ROW, OUT_LAST, BUSY, DONE.
  - Reset has priority over every other input.
  - Reset mid-drain abandons the transfer: no ARRAY_CLR and no DONE are issued, and ARRAY_HOLD drops the cycle after reset.
- States: IDLE, DRAIN, CLEAR. All outputs are registered.
- IDLE:
  - ARRAY_HOLD=0, OUT_VALID=0.
  - START=1 -> DRAIN. On the same edge: row pointer r=0, OUT_DATA<=RESULT[0], OUT_ROW<=0, OUT_VALID<=1, ARRAY_HOLD<=1, BUSY<=1.
  - Latency: START at cycle t -> OUT_VALID=1 and ARRAY_HOLD=1 at t+1.
- DRAIN:
  - ARRAY_HOLD=1 throughout.
  - Handshake: a transfer occurs on any edge with OUT_VALID && OUT_READY.
  - While OUT_VALID && !OUT_READY, OUT_DATA, OUT_ROW and OUT_LAST stay stable.
  - OUT_VALID never drops inside DRAIN until the last row is accepted.
  - Transfer with r<LENGTH-1: r<=r+1, OUT_DATA<=RESULT[r+1], OUT_ROW<=r+1 on the same edge. No bubble: back-to-back READY gives one row per cycle.
  - Transfer with r==LENGTH-1: OUT_VALID<=0, ARRAY_CLR<=1 -> CLEAR.
  - Total drain time with READY held high: LENGTH cycles.
- CLEAR (exactly one cycle):
  - ARRAY_CLR=1, ARRAY_HOLD=1.
  - Next edge: ARRAY_CLR<=0, ARRAY_HOLD<=0, BUSY<=0, DONE<=1 -> IDLE.
  - DONE is high for exactly one cycle.
- START while BUSY=1 is ignored; it is not queued.
- START is accepted in the same cycle DONE is high, since the state is already IDLE; OUT_VALID rises the following cycle.
- RESULT is sampled only at row-load edges. The frozen array guarantees it is stable.
- Row pointer wraps nowhere; it is reloaded to 0 only from IDLE.
- LENGTH==1: the single row carries OUT_LAST=1 on its first valid cycle.

Optional Feature:
- Macro: MMU_DRAIN_RELU_EN.
- Defined: each 2*WIDTH element is treated as signed two's complement. Any element with its MSB set is replaced by 0 when loaded into OUT_DATA. Non-negative elements pass unchanged. No added latency.
- Undefined: elements pass bit-exact, unsigned, with no comparison logic synthesized.

Test Plan:
- WIDTH=8, LENGTH=4, RESULT[r][c]=16*r+c, READY=1, START pulse at cycle 10 -> OUT_VALID cycles 11-14 with rows 0..3. Row 2 OUT_DATA = {0x0023,0x0022,0x0021,0x0020}. OUT_LAST only at cycle 14. ARRAY_CLR at 15. DONE at 16. ARRAY_HOLD high 11-15.
- Same stimulus, READY low for 3 cycles while row 1 is presented -> row 1 data and OUT_ROW=1 held 4 cycles. No row skipped or duplicated. DONE 3 cycles later than the first test.
- START re-pulsed during DRAIN at row 2 -> ignored. Exactly 4 transfers and one DONE.
- SYNC_RST=0 for one cycle while row 1 is valid -> all outputs 0 next cycle. No ARRAY_CLR, no DONE. A fresh START drains from row 0.
- MMU_DRAIN_RELU_EN defined, RESULT[0][0]=0xFF38 (-200), RESULT[0][1]=0x00C8 -> row 0 elements 0x0000, 0x00C8. Macro undefined -> 0xFF38, 0x00C8.
- START asserted in the DONE cycle -> second drain begins, OUT_VALID=1 the next cycle with OUT_ROW=0.
